// File: rtl/ldpc_enc_scheduler.sv
// ldpc_enc_scheduler: round-robin sharing of one LDPC encoder between NUM_REQ
// message sources. Sequences start, message load, encode wait, parity readout
// and parity-done release for the granted source.
// Optional watchdog: define LDPC_SCHED_WDOG_EN to abort stalled LOAD/WAIT_DONE
// phases after WDOG_CYC cycles (err pulse, encoder drained through PARITY).
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | no codeword in flight, arbitrating requests
//   START     | enc_start pulse to the encoder, message counter cleared
//   LOAD      | streaming MSG_LEN message words from the granted source
//   WAIT_DONE | message loaded, waiting for encoder done
//   PARITY    | reading out PAR_LEN parity words
//   RELEASE   | parity-done and cw_done pulse, grant dropped, rr advanced
module ldpc_enc_scheduler #(
    parameter int NUM_REQ  = 2,
    parameter int MSG_LEN  = 32,
    parameter int PAR_LEN  = 16,
    parameter int WDOG_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] src_valid,
    output logic [NUM_REQ-1:0] src_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               enc_start,
    output logic               enc_din,
    input  logic               enc_done,
    output logic               enc_read_parity,
    input  logic               enc_par_valid,
    output logic               enc_parity_done,
    output logic               busy,
    output logic               cw_done,
    output logic               err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int MW = $clog2(MSG_LEN);
    localparam int PW = $clog2(PAR_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_LOAD, S_WAIT_DONE, S_PARITY, S_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [MW-1:0]      msg_cnt_q, msg_cnt_d;
    logic [PW-1:0]      par_cnt_q, par_cnt_d;
    logic               par_seen_q, par_seen_d;
    logic               start_q, start_d;
    logic               pdone_q, pdone_d;
    logic               cwd_q, cwd_d;

    logic               xfer;
    logic               arb_found;
    logic [IW-1:0]      arb_idx;
    logic [IW-1:0]      cand;
    int unsigned        cand_i;
    logic               wdog_trip;

    // Round-robin pick: first requesting source at or after the rr pointer.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_i    = 0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_i = int'(rr_q) + i;
            if (cand_i >= NUM_REQ) cand_i = cand_i - NUM_REQ;
            cand = IW'(cand_i);
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    assign xfer = (state_q == S_LOAD) && src_valid[gidx_q];

`ifdef LDPC_SCHED_WDOG_EN
    localparam int SW = $clog2(WDOG_CYC + 1);
    logic [SW-1:0] stall_q, stall_d;
    logic          stalling;
    logic          err_q, err_d;

    // Stall counter: counts consecutive no-progress cycles in LOAD/WAIT_DONE.
    always_comb begin
        stalling = ((state_q == S_LOAD) && !src_valid[gidx_q]) ||
                   ((state_q == S_WAIT_DONE) && !enc_done);
        stall_d  = '0;
        if (stalling)
            stall_d = (stall_q == SW'(WDOG_CYC)) ? stall_q : stall_q + 1'b1;
        wdog_trip = stalling && (stall_q == SW'(WDOG_CYC - 1));
        err_d     = wdog_trip;
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wdog_trip = 1'b0;
    assign err       = 1'b0;
`endif

    // State register and all sequencing flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            gidx_q     <= '0;
            rr_q       <= '0;
            msg_cnt_q  <= '0;
            par_cnt_q  <= '0;
            par_seen_q <= 1'b0;
            start_q    <= 1'b0;
            pdone_q    <= 1'b0;
            cwd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gidx_q     <= gidx_d;
            rr_q       <= rr_d;
            msg_cnt_q  <= msg_cnt_d;
            par_cnt_q  <= par_cnt_d;
            par_seen_q <= par_seen_d;
            start_q    <= start_d;
            pdone_q    <= pdone_d;
            cwd_q      <= cwd_d;
        end
    end

    // Next-state, grant and counter update.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gidx_d     = gidx_q;
        rr_d       = rr_q;
        msg_cnt_d  = msg_cnt_q;
        par_cnt_d  = par_cnt_q;
        par_seen_d = par_seen_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d          = '0;
                    gnt_d[arb_idx] = 1'b1;
                    gidx_d         = arb_idx;
                    state_d        = S_START;
                end
            end
            S_START: begin
                msg_cnt_d = '0;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                if (xfer) begin
                    // Counter parks at its terminal value on the last word.
                    if (msg_cnt_q == MW'(MSG_LEN - 1)) state_d = S_WAIT_DONE;
                    else msg_cnt_d = msg_cnt_q + 1'b1;
                end else if (wdog_trip) begin
                    par_cnt_d  = '0;
                    par_seen_d = 1'b0;
                    state_d    = S_PARITY;
                end
            end
            S_WAIT_DONE: begin
                if (enc_done || wdog_trip) begin
                    par_cnt_d  = '0;
                    par_seen_d = 1'b0;
                    state_d    = S_PARITY;
                end
            end
            S_PARITY: begin
                if (enc_par_valid) begin
                    par_seen_d = 1'b1;
                    if (par_cnt_q == PW'(PAR_LEN - 1)) begin
                        par_cnt_d = PW'(PAR_LEN);
                        state_d   = S_RELEASE;
                    end else begin
                        par_cnt_d = par_cnt_q + 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                gnt_d   = '0;
                rr_d    = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: registered pulses keyed off the next state, handshakes from current state.
    always_comb begin
        start_d         = (state_d == S_START);
        pdone_d         = (state_d == S_RELEASE);
        cwd_d           = (state_d == S_RELEASE);
        src_ready       = '0;
        if (state_q == S_LOAD) src_ready[gidx_q] = src_valid[gidx_q];
        enc_din         = xfer;
        enc_read_parity = (state_q == S_PARITY) && !par_seen_q;
        busy            = (state_q != S_IDLE);
    end

    assign gnt             = gnt_q;
    assign enc_start       = start_q;
    assign enc_parity_done = pdone_q;
    assign cw_done         = cwd_q;
endmodule

// File: tb/tb_ldpc_enc_scheduler.sv
// Scoreboard bench for ldpc_enc_scheduler (NUM_REQ=2, MSG_LEN=4, PAR_LEN=3, WDOG_CYC=8).
// Build with LDPC_SCHED_WDOG_EN defined to exercise the watchdog abort path.
module tb_ldpc_enc_scheduler;
    localparam int MSG_LEN = 4;
    localparam int PAR_LEN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, src_valid, src_ready, gnt;
    logic       enc_start, enc_din, enc_done, enc_read_parity, enc_par_valid;
    logic       enc_parity_done, busy, cw_done, err;
    logic       mdl_done = 1'b0, stim_done = 1'b0;

    assign enc_done = mdl_done | stim_done;

    ldpc_enc_scheduler #(.NUM_REQ(2), .MSG_LEN(MSG_LEN), .PAR_LEN(PAR_LEN), .WDOG_CYC(8)) dut (
        .clk(clk), .rst(rst), .req(req), .src_valid(src_valid), .src_ready(src_ready),
        .gnt(gnt), .enc_start(enc_start), .enc_din(enc_din), .enc_done(enc_done),
        .enc_read_parity(enc_read_parity), .enc_par_valid(enc_par_valid),
        .enc_parity_done(enc_parity_done), .busy(busy), .cw_done(cw_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] gnt;
        int         din;
        int         err;
        int         busy;   // 0 = do not check busy-cycle count
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Encoder model: done 2 cycles after the MSG_LEN-th word, PAR_LEN parity words after read_parity.
    int din_n = 0, done_dly = 0, par_left = 0;
    bit par_armed = 0, nd, np;
    initial begin
        enc_par_valid = 1'b0;
        forever begin
            @(negedge clk);
            nd = 0; np = 0;
            if (rst) begin
                din_n = 0; done_dly = 0; par_left = 0; par_armed = 0;
            end else begin
                if (enc_start) din_n = 0;
                if (enc_din) begin
                    din_n++;
                    if (din_n == MSG_LEN) done_dly = 1;
                end else if (done_dly > 0) begin
                    done_dly--;
                    if (done_dly == 0) nd = 1;
                end
                if (enc_read_parity && !par_armed) begin
                    par_armed = 1; par_left = PAR_LEN;
                end
                if (par_left > 0) begin np = 1; par_left--; end
                if (enc_parity_done) par_armed = 0;
            end
            @(posedge clk); #1;
            mdl_done = nd; enc_par_valid = np;
        end
    end

    // Monitor: per-cycle invariants, per-codeword comparison on cw_done.
    int cyc = 0, last_cw = -100;
    int m_start = 0, m_din = 0, m_rp = 0, m_pd = 0, m_busy = 0, m_err = 0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            m_start = 0; m_din = 0; m_rp = 0; m_pd = 0; m_busy = 0; m_err = 0;
        end else begin
            checks++;
            if (((src_ready & ~gnt) != 2'b00) || !$onehot0(gnt)) begin
                errors++;
                $display("FAIL grant_ready: gnt=%b src_ready=%b, required one-hot gnt covering src_ready", gnt, src_ready);
            end
            if (busy) m_busy++;
            if (enc_start) begin
                m_start++;
                chk("start_gap_ge2", int'(cyc - last_cw >= 2), 1);
            end
            m_din += int'(enc_din);
            m_rp  += int'(enc_read_parity);
            m_pd  += int'(enc_parity_done);
            m_err += int'(err);
            if (cw_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cw_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("cw_gnt", int'(gnt), int'(e.gnt));
                    chk("cw_din", m_din, e.din);
                    chk("cw_err", m_err, e.err);
                    chk("cw_start", m_start, 1);
                    chk("cw_read_parity", m_rp, 2);
                    chk("cw_parity_done", m_pd, 1);
                    if (e.busy != 0) chk("cw_busy_cycles", m_busy, e.busy);
                end
                last_cw = cyc;
                m_start = 0; m_din = 0; m_rp = 0; m_pd = 0; m_busy = 0; m_err = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_cw(input int n, input int bound, input string name);
        int seen = 0;
        int k = 0;
        while (seen < n && k < bound) begin
            @(negedge clk);
            k++;
            if (cw_done) seen++;
        end
        chk(name, seen, n);
    endtask

    function automatic int outs();
        return int'({gnt, src_ready, enc_start, enc_din, enc_read_parity,
                     enc_parity_done, busy, cw_done, err});
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int k, bad, n;
        rst = 1'b1; req = 2'b00; src_valid = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 0);
        tick(); rst = 1'b0;
        tick();

        // 1: single source, continuous valid
        sb.push_back('{2'b01, 4, 0, 12});
        req = 2'b01; src_valid = 2'b01;
        wait_cw(1, 60, "t1_cw_timeout");
        tick(); req = 2'b00; src_valid = 2'b00;
        @(negedge clk);
        chk("t1_busy_low", int'(busy), 0);

        // 2: both sources requesting from reset, round-robin alternation
        tick(); rst = 1'b1; req = 2'b11; src_valid = 2'b11;
        sb.push_back('{2'b01, 4, 0, 12});
        sb.push_back('{2'b10, 4, 0, 12});
        sb.push_back('{2'b01, 4, 0, 12});
        tick(); rst = 1'b0;
        wait_cw(3, 120, "t2_cw_timeout");
        tick(); req = 2'b00; src_valid = 2'b00;

        // 3: toggling valid, non-granted source valid, early done pulses in LOAD
        tick();
        sb.push_back('{2'b01, 4, 0, 0});
        req = 2'b01; src_valid = 2'b10;
        k = 0;
        do begin @(negedge clk); k++; end while (gnt == 2'b00 && k < 10);
        chk("t3_grant_seen", int'(gnt), 1);
        k = 0;
        n = 0;
        while (k < 40) begin
            tick();
            src_valid[0] = (k % 2 == 0);
            stim_done    = (k == 1 || k == 3);
            @(negedge clk);
            k++;
            if (cw_done) begin n = 1; break; end
        end
        chk("t3_cw_timeout", n, 1);
        tick(); req = 2'b00; src_valid = 2'b00; stim_done = 1'b0;

        // 4: reset in PARITY after first parity word; rr must restart at 0
        tick();
        req = 2'b01; src_valid = 2'b01;
        k = 0;
        do begin @(negedge clk); k++; end while (!enc_par_valid && k < 40);
        chk("t4_par_valid_seen", int'(enc_par_valid), 1);
        tick(); rst = 1'b1; req = 2'b00; src_valid = 2'b00;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t4_reset_outputs", outs(), 0);
        tick();
        sb.push_back('{2'b01, 4, 0, 12});
        req = 2'b11; src_valid = 2'b11;
        wait_cw(1, 60, "t4_cw_timeout");
        tick(); req = 2'b00; src_valid = 2'b00;

        // 5/6: source stalls after two words
        tick();
`ifdef LDPC_SCHED_WDOG_EN
        sb.push_back('{2'b01, 2, 1, 16});
`else
        sb.push_back('{2'b01, 4, 0, 0});
`endif
        req = 2'b01; src_valid = 2'b01;
        k = 0; n = 0;
        while (n < 2 && k < 20) begin
            @(negedge clk); k++;
            if (enc_din) n++;
        end
        chk("t5_two_words", n, 2);
        tick(); src_valid = 2'b00;
`ifdef LDPC_SCHED_WDOG_EN
        wait_cw(1, 60, "t5_cw_timeout");
`else
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (err || gnt != 2'b01 || !busy || enc_read_parity || enc_din) bad++;
        end
        chk("t6_hold_in_load", bad, 0);
        tick(); src_valid = 2'b01;
        wait_cw(1, 60, "t6_cw_timeout");
`endif
        tick(); req = 2'b00; src_valid = 2'b00;

        repeat (4) tick();
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
